// File: rtl/alarm_ctrl_if.sv
// Button-edge, trigger and steering signals between the alarm clock's front end and alarm_ctrl.
// The master side drives the buttons, tick and trigger; the slave side (alarm_ctrl) drives the outputs.
interface alarm_ctrl_if;
    logic       tick_1hz;
    logic       mode_btn;
    logic       hr_btn;
    logic       min_btn;
    logic       stop_btn;
    logic       snooze_btn;
    logic       alarm_trig;
    logic [1:0] clk_edit_btns;
    logic [1:0] alm_edit_btns;
    logic       alarm_mode;
    logic       disp_alarm;
    logic       buzzer;
    logic [2:0] snoozes;

    modport master (
        output tick_1hz, mode_btn, hr_btn, min_btn, stop_btn, snooze_btn, alarm_trig,
        input  clk_edit_btns, alm_edit_btns, alarm_mode, disp_alarm, buzzer, snoozes
    );

    modport slave (
        input  tick_1hz, mode_btn, hr_btn, min_btn, stop_btn, snooze_btn, alarm_trig,
        output clk_edit_btns, alm_edit_btns, alarm_mode, disp_alarm, buzzer, snoozes
    );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm clock mode / alarm sequencing controller: user edit modes, edit steering,
// and the ring / snooze / timeout sequence. All outputs are registered.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   CLOCK     | normal timekeeping display, alarm armed
//   SET_TIME  | hr/min edits go to the timekeeping counter
//   SET_ALARM | hr/min edits go to the alarm register, alarm shown
//   RINGING   | buzzer on, ring counter counting down seconds
//   SNOOZED   | buzzer off, snooze counter counting down seconds
module alarm_ctrl #(
    parameter int RING_SECS  = 60,
    parameter int SNOOZE_MIN = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic         clk,
    input  logic         reset,
    alarm_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        CLOCK     = 3'd0,
        SET_TIME  = 3'd1,
        SET_ALARM = 3'd2,
        RINGING   = 3'd3,
        SNOOZED   = 3'd4
    } state_t;

    localparam logic [7:0]  RING_LOAD  = 8'(RING_SECS);
    localparam logic [11:0] SNZ_LOAD   = 12'(SNOOZE_MIN * 60);
    localparam logic [2:0]  SNOOZE_CAP = 3'(MAX_SNOOZE);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  ring_cnt;
    logic [7:0]  ring_nxt;
    logic [11:0] snz_cnt;
    logic [11:0] snz_nxt;
    logic [2:0]  snoozes;
    logic [2:0]  snoozes_nxt;
    logic        trig_d;
    logic        trig_rise;
    logic        at_max;

    logic [1:0]  clk_edit_q;
    logic [1:0]  alm_edit_q;
    logic        alarm_mode_q;
    logic        disp_alarm_q;
    logic        buzzer_q;

    // Edge detection keeps a still-matching alarm second from re-ringing after stop.
    assign trig_rise = bus.alarm_trig & ~trig_d;
    assign at_max    = (snoozes >= SNOOZE_CAP);

    always_comb begin
        state_nxt   = state;
        ring_nxt    = ring_cnt;
        snz_nxt     = snz_cnt;
        snoozes_nxt = snoozes;
        case (state)
            CLOCK: begin
                if (trig_rise) begin
                    state_nxt   = RINGING;
                    ring_nxt    = RING_LOAD;
                    snoozes_nxt = 3'd0;
                end else if (bus.mode_btn) begin
                    state_nxt = SET_TIME;
                end
            end
            SET_TIME: begin
                if (bus.mode_btn) state_nxt = SET_ALARM;
            end
            SET_ALARM: begin
                if (bus.mode_btn) state_nxt = CLOCK;
            end
            RINGING: begin
                // Buttons take priority over the tick that would end the ring.
                if (bus.stop_btn || (bus.snooze_btn && at_max)) begin
                    state_nxt   = CLOCK;
                    snoozes_nxt = 3'd0;
                end else if (bus.snooze_btn) begin
                    state_nxt   = SNOOZED;
                    snoozes_nxt = 3'(snoozes + 3'd1);
                    snz_nxt     = SNZ_LOAD;
                end else if (bus.tick_1hz) begin
                    if (ring_cnt <= 8'd1) begin
                        state_nxt   = CLOCK;
                        ring_nxt    = 8'd0;
                        snoozes_nxt = 3'd0;
                    end else begin
                        ring_nxt = ring_cnt - 8'd1;
                    end
                end
            end
            SNOOZED: begin
                if (bus.stop_btn) begin
                    state_nxt   = CLOCK;
                    snoozes_nxt = 3'd0;
                end else if (trig_rise) begin
                    state_nxt = RINGING;
                    ring_nxt  = RING_LOAD;
                end else if (bus.tick_1hz) begin
                    if (snz_cnt <= 12'd1) begin
                        state_nxt = RINGING;
                        ring_nxt  = RING_LOAD;
                        snz_nxt   = 12'd0;
                    end else begin
                        snz_nxt = snz_cnt - 12'd1;
                    end
                end
            end
            default: begin
                state_nxt = CLOCK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= CLOCK;
            ring_cnt     <= 8'd0;
            snz_cnt      <= 12'd0;
            snoozes      <= 3'd0;
            trig_d       <= 1'b0;
            clk_edit_q   <= 2'b00;
            alm_edit_q   <= 2'b00;
            alarm_mode_q <= 1'b0;
            disp_alarm_q <= 1'b0;
            buzzer_q     <= 1'b0;
        end else begin
            state        <= state_nxt;
            ring_cnt     <= ring_nxt;
            snz_cnt      <= snz_nxt;
            snoozes      <= snoozes_nxt;
            trig_d       <= bus.alarm_trig;
            // Edit steering follows the mode the button was pressed in.
            clk_edit_q   <= (state == SET_TIME)  ? {bus.hr_btn, bus.min_btn} : 2'b00;
            alm_edit_q   <= (state == SET_ALARM) ? {bus.hr_btn, bus.min_btn} : 2'b00;
            alarm_mode_q <= (state_nxt == SET_TIME) || (state_nxt == SET_ALARM);
            disp_alarm_q <= (state_nxt == SET_ALARM);
            buzzer_q     <= (state_nxt == RINGING);
        end
    end

    assign bus.clk_edit_btns = clk_edit_q;
    assign bus.alm_edit_btns = alm_edit_q;
    assign bus.alarm_mode    = alarm_mode_q;
    assign bus.disp_alarm    = disp_alarm_q;
    assign bus.buzzer        = buzzer_q;
    assign bus.snoozes       = snoozes;

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
Top-level mode and alarm-sequencing controller for the alarm clock.
- Owns the user-mode state machine (clock / set time / set alarm).
- Steers edited hour/minute button edges to either the timekeeping counter or the alarm register block.
- Drives the alarm block's mode input.
- Runs the ringing / snooze / timeout sequence off the alarm trigger and a 1 Hz tick.
- Sits between the button edge detectors and the clock, alarm and display blocks.

Parameters:
RING_SECS, 60, seconds the buzzer rings before auto-stop (1..255)
SNOOZE_MIN, 5, snooze delay in minutes (1..59)
MAX_SNOOZE, 3, snoozes allowed per alarm event (1..7); further snooze presses act as stop

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
tick_1hz  input  1  one-cycle pulse, once per second
mode_btn  input  1  mode button edge (one-cycle pulse)
hr_btn  input  1  hours button edge
min_btn  input  1  minutes button edge
stop_btn  input  1  stop button edge
snooze_btn  input  1  snooze button edge
alarm_trig  input  1  alarm block trigger (level, high for the whole matching second)
clk_edit_btns  output  2  {hours, minutes} edit pulses to timekeeping counter
alm_edit_btns  output  2  {hours, minutes} edit pulses to alarm block
alarm_mode  output  1  to alarm block mode input; 1 = trigger suppressed
disp_alarm  output  1  1 = display shows alarm time, 0 = current time
buzzer  output  1  buzzer enable
snoozes  output  3  snoozes used in current alarm event

Behaviour:
- Reset is asynchronous, active-low; clk is the only clock.
- Reset values: state = CLOCK, all outputs 0, counters 0, trig_d = 0.
- Reset asserted mid-ring or mid-snooze: buzzer drops immediately (asynchronously); the pending snooze is discarded.
- States: CLOCK, SET_TIME, SET_ALARM, RINGING, SNOOZED. All outputs are registered.
- trig_rise = alarm_trig & ~trig_d, where trig_d is alarm_trig delayed by one cycle.
- CLOCK:
  - mode_btn -> SET_TIME.
  - trig_rise -> RINGING; ring counter loaded with RING_SECS; snoozes = 0.
  - If mode_btn and trig_rise arrive in the same cycle, trig_rise wins.
- SET_TIME:
  - mode_btn -> SET_ALARM.
  - hr_btn/min_btn appear on clk_edit_btns[1]/[0] one cycle later, one cycle wide.
- SET_ALARM:
  - mode_btn -> CLOCK.
  - Buttons appear on alm_edit_btns, same 1-cycle latency.
  - disp_alarm = 1.
- Edit routing rules:
  - hr_btn and min_btn in the same cycle are both forwarded.
  - In every state other than SET_TIME/SET_ALARM, both edit outputs are 0 and the buttons are ignored.
- alarm_mode = 1 in SET_TIME and SET_ALARM; 0 otherwise.
- RINGING:
  - buzzer = 1.
  - Each tick_1hz decrements the ring counter.
  - Counter reaching 0 -> CLOCK; buzzer low the next cycle; snoozes cleared.
  - stop_btn -> CLOCK, snoozes cleared.
  - snooze_btn with snoozes < MAX_SNOOZE -> SNOOZED; snoozes += 1; snooze counter loaded with SNOOZE_MIN*60.
  - snooze_btn with snoozes == MAX_SNOOZE behaves as stop.
  - stop_btn and snooze_btn in the same cycle: stop wins.
  - A button and the final tick in the same cycle: the button wins.
  - mode_btn, hr_btn and min_btn are ignored.
- SNOOZED:
  - buzzer = 0.
  - Each tick decrements the snooze counter (width ceil(log2(59*60+1)) = 12 bits).
  - Counter reaching 0 -> RINGING, ring counter reloaded, snoozes kept.
  - stop_btn -> CLOCK, snoozes cleared.
  - A new trig_rise -> RINGING, ring counter reloaded, snoozes kept.
  - mode_btn is ignored.
- Buzzer latency: RINGING entry raises buzzer on the clock edge following the causing event.
- The alarm re-matching within the same second after stop cannot re-ring, because ringing is edge-triggered on alarm_trig.

Test Plan:
1. Reset low mid-operation, release; mode_btn x3 -> states step SET_TIME, SET_ALARM, CLOCK; alarm_mode goes 1, 1, 0; disp_alarm = 1 only in SET_ALARM.
2. In SET_TIME, pulse hr_btn and min_btn together -> clk_edit_btns = 2'b11 for exactly 1 cycle, 1 cycle later, alm_edit_btns stays 0; repeat in SET_ALARM -> alm_edit_btns = 2'b11 only; in CLOCK -> both 0.
3. CLOCK, alarm_trig high for 1000 cycles with RING_SECS=3, three ticks -> buzzer high from cycle after rise, low the cycle after the 3rd tick, no re-ring while alarm_trig stays high.
4. Ringing, snooze_btn with SNOOZE_MIN=1 -> buzzer off, snoozes = 1; after 60 ticks buzzer on again; snooze again -> snoozes = 2.
5. MAX_SNOOZE=1: ring, snooze, re-ring, snooze_btn -> returns to CLOCK, buzzer 0, snoozes = 0.
6. Ringing, stop_btn and snooze_btn in same cycle -> CLOCK, buzzer 0, snoozes = 0; mode_btn and trig_rise same cycle in CLOCK -> RINGING.
